autosym_projector: RTL and testbench

//  Sequential GF(2) affine projector: the front end that feeds an autosymmetric

---
 rtl/autosym_projector.sv | 106 ++++++++++
 tb/tb_autosym_projector.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/autosym_projector.sv
// rtl/autosym_projector.sv - sequential GF(2) affine projector y = A*x ^ c, one row of A per clock
module autosym_projector #(
    parameter int N_IN  = 23,
    parameter int K_OUT = 13,
    parameter int RW    = $clog2(K_OUT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [RW-1:0]    cfg_row,
    input  logic [N_IN-1:0]  cfg_mask,
    input  logic             cfg_cbit,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K_OUT-1:0] out_y,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, COMP, DONE} state_t;

    localparam logic [RW:0]   ROW_LIMIT = (RW+1)'(K_OUT);
    localparam logic [RW-1:0] LAST_ROW  = RW'(K_OUT - 1);

    state_t            state;
    logic [N_IN-1:0]   rows [K_OUT];
    logic [K_OUT-1:0]  cbits;
    logic [K_OUT-1:0]  y_acc;
    logic [K_OUT-1:0]  acc_nxt;
    logic [N_IN-1:0]   x_r;
    logic [RW-1:0]     r;
    logic              cfg_ok;

    // Writes are legal only while no operation is reading the rows.
    assign cfg_ok = (state == IDLE) && ({1'b0, cfg_row} < ROW_LIMIT);

    always_comb begin
        acc_nxt    = y_acc;
        acc_nxt[r] = (^(rows[r] & x_r)) ^ cbits[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < K_OUT; i++) begin
                rows[i] <= '0;
            end
            cbits     <= '0;
            state     <= IDLE;
            x_r       <= '0;
            r         <= '0;
            y_acc     <= '0;
            out_y     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                rows[cfg_row]  <= cfg_mask;
                cbits[cfg_row] <= cfg_cbit;
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r      <= in_x;
                        r        <= '0;
                        y_acc    <= '0;
                        state    <= COMP;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                COMP: begin
                    y_acc <= acc_nxt;
                    if (r == LAST_ROW) begin
                        out_y     <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        r <= r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_autosym_projector.sv
// tb/tb_autosym_projector.sv - directed self-checking bench for autosym_projector
module tb_autosym_projector;

    localparam int N_IN  = 23;
    localparam int K_OUT = 13;
    localparam int RW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [RW-1:0]    cfg_row;
    logic [N_IN-1:0]  cfg_mask;
    logic             cfg_cbit;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  in_x;
    logic             out_valid;
    logic             out_ready;
    logic [K_OUT-1:0] out_y;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    autosym_projector #(.N_IN(N_IN), .K_OUT(K_OUT), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_mask(cfg_mask), .cfg_cbit(cfg_cbit),
        .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int row, input logic [N_IN-1:0] mask, input logic c,
                       input logic exp_err);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_row  = RW'(row);
        cfg_mask = mask;
        cfg_cbit = c;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("cfg_err", {31'b0, cfg_err}, {31'b0, exp_err});
    endtask

    task automatic set_identity();
        for (int i = 0; i < K_OUT; i++) begin
            cfg(i, N_IN'(1) << i, 1'b0, 1'b0);
        end
    endtask

    // Ends on the negedge following the accepting edge.
    task automatic start_op(input logic [N_IN-1:0] x);
        @(negedge clk);
        chk("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_x     = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_x     = ~x;
        chk("busy_in_comp", {31'b0, busy}, 32'd1);
    endtask

    // n0 = negedges already elapsed since the one right after acceptance.
    task automatic finish_op(input logic [K_OUT-1:0] exp_y, input int n0, input string tag);
        int n;
        n = n0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(K_OUT));
        chk({tag, "_out_y"}, {19'b0, out_y}, {19'b0, exp_y});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [K_OUT-1:0] held;
        int               bad;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_mask = '0; cfg_cbit = 1'b0;
        in_valid = 1'b0; in_x = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_y", {19'b0, out_y}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
        rst_n = 1'b1;

        // Reset map yields zero for any x.
        start_op(23'h123456);
        finish_op(13'h0000, 0, "reset_map");

        // Identity map.
        set_identity();
        start_op(23'h5A5A5A);
        finish_op(13'h1A5A, 0, "identity");

        // Write accepted in the same cycle as in_x is visible to that operation.
        @(negedge clk);
        cfg_we = 1'b1; cfg_row = 4'd0; cfg_mask = 23'h7FFFFF; cfg_cbit = 1'b1;
        in_valid = 1'b1; in_x = 23'h5A5A5A;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("same_cycle_cfg_err", {31'b0, cfg_err}, 32'd0);
        finish_op(13'h1A5B, 0, "same_cycle_cfg");

        // Backpressure: output held, no new acceptance.
        cfg(0, 23'h000001, 1'b0, 1'b0);
        start_op(23'h7FFFFF);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("bp_latency", 32'(n), 32'(K_OUT));
        end
        held = out_y;
        chk("bp_out_y", {19'b0, held}, 32'h1FFF);
        in_valid = 1'b1; in_x = 23'h000000;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_y !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
        chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        chk("bp_no_accept_busy", {31'b0, busy}, 32'd0);

        // Illegal configuration during COMP is dropped.
        start_op(23'h5A5A5A);
        cfg_we = 1'b1; cfg_row = 4'd12; cfg_mask = 23'h000000; cfg_cbit = 1'b0;
        @(negedge clk);
        cfg_we = 1'b0;
        chk("comp_cfg_err_pulse", {31'b0, cfg_err}, 32'd1);
        @(negedge clk);
        chk("comp_cfg_err_clear", {31'b0, cfg_err}, 32'd0);
        finish_op(13'h1A5A, 2, "comp_cfg");
        start_op(23'h5A5A5A);
        finish_op(13'h1A5A, 0, "comp_cfg_row_kept");

        // Out-of-range row in IDLE.
        cfg(13, 23'h7FFFFF, 1'b1, 1'b1);
        @(negedge clk);
        chk("bad_row_err_clear", {31'b0, cfg_err}, 32'd0);

        // Affine bit and all-ones parity.
        cfg(0, 23'h7FFFFF, 1'b1, 1'b0);
        for (int i = 1; i < K_OUT; i++) begin
            cfg(i, 23'h000000, 1'b0, 1'b0);
        end
        start_op(23'h000007);
        finish_op(13'h0000, 0, "parity_odd");
        start_op(23'h000003);
        finish_op(13'h0001, 0, "parity_even");
        cfg(1, 23'h000000, 1'b1, 1'b0);
        start_op(23'h000003);
        finish_op(13'h0003, 0, "zero_row_cbit");

        // Mid-operation asynchronous reset.
        set_identity();
        start_op(23'h5A5A5A);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(23'h5A5A5A);
        finish_op(13'h0000, 0, "after_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
